// File: rtl/car_motion_ctrl.sv
// rtl/car_motion_ctrl.sv - elevator car motion controller for a 4-storey car
//
// Steps the car one floor per travel interval, stops at requested floors,
// times the door and reverses or idles when no demand remains ahead.
//
// Ports:
//   clk        system clock (32 Hz), rising edge
//   rst_n      asynchronous active-low reset
//   up_need    demand above the car (from request block)
//   down_need  demand below the car (from request block)
//   allReq     active request mask, bit0 = floor 1
//   door_hold  door-open button, level-sensitive
//   position   one-hot car floor, bit0 = floor 1
//   ud_mode    00 stop, 01 up, 10 down
//   door_open  door open indicator
//   moving     high while travelling between floors
//   floor_bin  binary floor index 0..3

module car_motion_ctrl #(
    parameter int TRAVEL_TICKS = 64,
    parameter int DOOR_TICKS   = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_need,
    input  logic       down_need,
    input  logic [3:0] allReq,
    input  logic       door_hold,
    output logic [3:0] position,
    output logic [1:0] ud_mode,
    output logic       door_open,
    output logic       moving,
    output logic [1:0] floor_bin
);

    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TW        = $clog2(MAX_TICKS);

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);

    localparam logic [1:0] UD_STOP = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DOOR   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      pos_q, pos_d;
    logic [1:0]      ud_q, ud_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [3:0] above_mask;
    logic [3:0] below_mask;
    logic [3:0] step_pos;
    logic       step_terminal;
    logic       here_req;
    logic       ahead_req;
    logic       behind_req;
    logic       idle_up;
    logic       idle_down;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_q   <= 4'b0001;
            ud_q    <= UD_STOP;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            ud_q    <= ud_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        // Floors strictly above / below the one-hot position.
        above_mask = {|pos_q[2:0], |pos_q[1:0], pos_q[0], 1'b0};
        below_mask = {1'b0, pos_q[3], |pos_q[3:2], |pos_q[3:1]};

        // Saturating one-floor step in the held direction; never leaves 1..4.
        step_pos = pos_q;
        if (ud_q == UD_UP && !pos_q[3]) begin
            step_pos = {pos_q[2:0], 1'b0};
        end else if (ud_q == UD_DOWN && !pos_q[0]) begin
            step_pos = {1'b0, pos_q[3:1]};
        end
        step_terminal = (ud_q == UD_UP && step_pos[3]) || (ud_q == UD_DOWN && step_pos[0]);

        here_req = |(allReq & pos_q);
        // A terminal floor has an empty mask in its travel direction, so
        // demand "ahead" there is naturally treated as none.
        ahead_req  = (ud_q == UD_UP)   ? |(allReq & above_mask) :
                     (ud_q == UD_DOWN) ? |(allReq & below_mask) : 1'b0;
        behind_req = (ud_q == UD_UP)   ? |(allReq & below_mask) :
                     (ud_q == UD_DOWN) ? |(allReq & above_mask) : 1'b0;

        idle_up   = up_need && !pos_q[3];
        idle_down = down_need && !pos_q[0];
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        ud_d    = ud_q;
        timer_d = timer_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                ud_d    = UD_STOP;
                timer_d = '0;
                if (here_req) begin
                    state_d = ST_DOOR;
                end else if (idle_up) begin
                    ud_d    = UD_UP;
                    state_d = ST_MOVING;
                end else if (idle_down) begin
                    ud_d    = UD_DOWN;
                    state_d = ST_MOVING;
                end
            end

            ST_MOVING: begin
                if (ud_q == UD_STOP) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    pos_d   = step_pos;
                    if (|(allReq & step_pos) || step_terminal) begin
                        state_d = ST_DOOR;
                    end
                end
            end

            ST_DOOR: begin
                if (door_hold) begin
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    if (ud_q == UD_STOP) begin
                        // Door opened from IDLE: same priority as IDLE.
                        if (here_req) begin
                            state_d = ST_DOOR;
                        end else if (idle_up) begin
                            ud_d    = UD_UP;
                            state_d = ST_MOVING;
                        end else if (idle_down) begin
                            ud_d    = UD_DOWN;
                            state_d = ST_MOVING;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (ahead_req) begin
                        state_d = ST_MOVING;
                    end else if (behind_req) begin
                        ud_d    = (ud_q == UD_UP) ? UD_DOWN : UD_UP;
                        state_d = ST_MOVING;
                    end else begin
                        ud_d    = UD_STOP;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                pos_d   = 4'b0001;
                ud_d    = UD_STOP;
                timer_d = '0;
            end
        endcase
    end

    assign position  = pos_q;
    assign ud_mode   = ud_q;
    assign door_open = (state_q == ST_DOOR);
    assign moving    = (state_q == ST_MOVING);

    always_comb begin
        floor_bin = 2'd0;
        case (pos_q)
            4'b0010: floor_bin = 2'd1;
            4'b0100: floor_bin = 2'd2;
            4'b1000: floor_bin = 2'd3;
            default: floor_bin = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb/tb_car_motion_ctrl.sv - self-checking bench for car_motion_ctrl

module tb_car_motion_ctrl;

    logic       clk;
    logic       rst_n;
    logic       up_need;
    logic       down_need;
    logic [3:0] all_req;
    logic       door_hold;
    logic [3:0] position;
    logic [1:0] ud_mode;
    logic       door_open;
    logic       moving;
    logic [1:0] floor_bin;

    car_motion_ctrl #(
        .TRAVEL_TICKS(4),
        .DOOR_TICKS  (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_need  (up_need),
        .down_need(down_need),
        .allReq   (all_req),
        .door_hold(door_hold),
        .position (position),
        .ud_mode  (ud_mode),
        .door_open(door_open),
        .moving   (moving),
        .floor_bin(floor_bin)
    );

    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DN   = 2'b10;
    localparam logic [9:0] RESET_VEC = {4'b0001, 2'b00, 1'b0, 1'b0, 2'b00};

    typedef struct {
        logic [9:0] vec;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [9:0] prev_vec;
    logic [9:0] obs_vec;

    assign obs_vec = {position, ud_mode, door_open, moving, floor_bin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [9:0] pack_vec(input logic [3:0] p, input logic [1:0] u,
                                            input logic d, input logic m);
        logic [1:0] fb;
        case (p)
            4'b0010: fb = 2'd1;
            4'b0100: fb = 2'd2;
            4'b1000: fb = 2'd3;
            default: fb = 2'd0;
        endcase
        return {p, u, d, m, fb};
    endfunction

    task automatic expect_at(input int at, input logic [3:0] p, input logic [1:0] u,
                             input logic d, input logic m);
        ev_t e;
        e.vec = pack_vec(p, u, d, m);
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every output change is matched against the oldest expectation.
    always @(negedge clk) begin
        if (obs_vec !== prev_vec) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_change", int'(obs_vec), int'(prev_vec));
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check_eq("out_vec", int'(obs_vec), int'(e.vec));
                check_eq("out_cycle", cyc, e.cyc);
            end
            prev_vec = obs_vec;
        end
    end

    // Async reset pulse; outputs must drop before the next clock edge.
    task automatic pulse_reset(input bit expect_change);
        int c;
        @(negedge clk);
        c = cyc;
        #1;
        if (expect_change) expect_at(c + 1, 4'b0001, STOP, 1'b0, 1'b0);
        rst_n     = 1'b0;
        all_req   = 4'b0000;
        up_need   = 1'b0;
        down_need = 1'b0;
        door_hold = 1'b0;
        #1;
        check_eq("async_reset", int'(obs_vec), int'(RESET_VEC));
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        prev_vec  = RESET_VEC;
        rst_n     = 1'b1;
        up_need   = 1'b0;
        down_need = 1'b0;
        all_req   = 4'b0000;
        door_hold = 1'b0;
        #1 rst_n  = 1'b0;
        step(2);
        check_eq("reset_state", int'(obs_vec), int'(RESET_VEC));
        rst_n = 1'b1;

        // Idle with no requests for 50 cycles.
        step(50);
        check_eq("idle_hold", int'(obs_vec), int'(RESET_VEC));

        // Floor 1 -> floor 4, door, idle.
        c = cyc;
        all_req = 4'b1000;
        up_need = 1'b1;
        expect_at(c + 1,  4'b0001, UP, 1'b0, 1'b1);
        expect_at(c + 5,  4'b0010, UP, 1'b0, 1'b1);
        expect_at(c + 9,  4'b0100, UP, 1'b0, 1'b1);
        expect_at(c + 13, 4'b1000, UP, 1'b1, 1'b0);
        expect_at(c + 19, 4'b1000, STOP, 1'b0, 1'b0);
        step(13);
        all_req = 4'b0000;
        up_need = 1'b0;
        step(10);
        check_eq("drain_up_trip", exp_q.size(), 0);

        // Door from IDLE at floor 4 with door_hold held for 10 cycles.
        c = cyc;
        all_req = 4'b1000;
        expect_at(c + 1, 4'b1000, STOP, 1'b1, 1'b0);
        step(1);
        all_req = 4'b0000;
        step(2);
        door_hold = 1'b1;
        step(10);
        door_hold = 1'b0;
        expect_at(c + 19, 4'b1000, STOP, 1'b0, 1'b0);
        step(10);
        check_eq("drain_door_hold", exp_q.size(), 0);

        pulse_reset(1'b1);
        step(3);
        check_eq("drain_reset1", exp_q.size(), 0);

        // Stop at 2, continue to 3, reverse down to terminal floor 1, idle.
        c = cyc;
        all_req = 4'b0100;
        up_need = 1'b1;
        expect_at(c + 1, 4'b0001, UP, 1'b0, 1'b1);
        step(2);
        all_req = 4'b0110;
        expect_at(c + 5, 4'b0010, UP, 1'b1, 1'b0);
        step(4);
        all_req = 4'b0100;
        expect_at(c + 11, 4'b0010, UP, 1'b0, 1'b1);
        expect_at(c + 15, 4'b0100, UP, 1'b1, 1'b0);
        step(10);
        all_req   = 4'b0001;
        up_need   = 1'b0;
        down_need = 1'b1;
        expect_at(c + 21, 4'b0100, DN, 1'b0, 1'b1);
        expect_at(c + 25, 4'b0010, DN, 1'b0, 1'b1);
        expect_at(c + 29, 4'b0001, DN, 1'b1, 1'b0);
        step(14);
        all_req   = 4'b0000;
        down_need = 1'b0;
        expect_at(c + 35, 4'b0001, STOP, 1'b0, 1'b0);
        step(10);
        check_eq("drain_multi_stop", exp_q.size(), 0);

        // Both needs high: up wins; reset mid-move between floors 2 and 3.
        c = cyc;
        all_req   = 4'b1000;
        up_need   = 1'b1;
        down_need = 1'b1;
        expect_at(c + 1, 4'b0001, UP, 1'b0, 1'b1);
        expect_at(c + 5, 4'b0010, UP, 1'b0, 1'b1);
        step(6);
        pulse_reset(1'b1);
        step(5);
        check_eq("post_reset_idle", int'(obs_vec), int'(RESET_VEC));
        check_eq("drain_final", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/car_motion_ctrl.md
Name: car_motion_ctrl

Overview:
Car motion controller for the 4-storey elevator. It consumes the request block's outputs (up_need, down_need, allReq_reg) and closes the loop by driving the position and ud_mode signals that the request block uses to clear served requests. It steps the car one floor per travel interval, stops at requested floors, times the door, and reverses or idles when no demand remains ahead. It runs on the same 32 Hz clock as the request block.

Parameters:
TRAVEL_TICKS, 64, clk cycles per floor-to-floor move (2 s at 32 Hz); must be >= 2
DOOR_TICKS, 96, clk cycles the door stays open per stop (3 s at 32 Hz); must be >= 2

Ports:
clk  input  1  32 Hz system clock; all state changes on the rising edge
rst_n  input  1  reset, asynchronous, active-low
up_need  input  1  request block reports demand above the car
down_need  input  1  request block reports demand below the car
allReq  input  4  one-hot-per-floor active request mask, bit0 = floor 1
door_hold  input  1  door-open button, level-sensitive
position  output  4  one-hot car floor, bit0 = floor 1
ud_mode  output  2  00 stop, 01 up, 10 down; 11 never driven
door_open  output  1  door open indicator
moving  output  1  high while the car travels between floors
floor_bin  output  2  binary floor index 0..3, for the display

Behaviour:
- Reset (async assert, sync deassert use): position=4'b0001, ud_mode=00, door_open=0, moving=0, floor_bin=0, state IDLE, timer=0. Assertion mid-move or mid-door returns to floor 1 immediately.
- floor_bin is always the encoding of position. position is always exactly one-hot.
- Masks: above = floors strictly higher than position; below = floors strictly lower.
- State IDLE: ud_mode=00, door_open=0, moving=0. Priority on each edge:
  - If (allReq & position) != 0: go to DOOR and keep ud_mode=00.
  - Else if up_need: ud_mode=01, go to MOVING.
  - Else if down_need: ud_mode=10, go to MOVING.
  - If up_need and down_need are both high, up wins.
- State MOVING: moving=1 and ud_mode is held. The timer counts 0..TRAVEL_TICKS-1.
  - On the edge where timer==TRAVEL_TICKS-1, position shifts one floor: left for 01, right for 10. The timer reloads to 0.
  - Latency: the first position change occurs TRAVEL_TICKS cycles after entering MOVING.
  - On that same edge, if (allReq & next_position) != 0, or next_position is a terminal floor (4 going up, 1 going down): go to DOOR. Otherwise stay in MOVING.
  - allReq bits for the floor being departed are ignored during travel.
- State DOOR: door_open=1, moving=0. ud_mode keeps the travel direction so the request block clears the served floor. The timer counts 0..DOOR_TICKS-1.
  - door_hold high resets the timer to 0 every cycle it is asserted.
  - On the expiry edge (door_open falls the next cycle), take the first matching branch:
    - Direction 01 and (allReq & above) != 0: MOVING, ud_mode 01.
    - Direction 10 and (allReq & below) != 0: MOVING, ud_mode 10.
    - Else if (allReq & the opposite mask) != 0: reverse ud_mode, go to MOVING.
    - Else: ud_mode=00, go to IDLE.
  - From an IDLE-entered door (ud_mode 00), apply the IDLE priority instead.
- Terminal floors: the car never shifts past floor 4 or floor 1. At a terminal floor, if demand lies only in the travel direction, treat it as none and reverse or idle.
- Timer width: ceil(log2(max(TRAVEL_TICKS, DOOR_TICKS))) bits. The timer resets to 0 on every state change.
- Requests arriving during DOOR at the current floor extend nothing. They are cleared by the request block while ud_mode is non-zero.

Test Plan:
All scenarios use TRAVEL_TICKS=4 and DOOR_TICKS=6.
- Reset release with no requests -> position=0001, ud_mode=00, door_open=0 held for 50 cycles.
- From floor 1, allReq=1000 and up_need=1 -> ud_mode=01 the next cycle. position steps 0010, 0100, 1000 at 4-cycle intervals. door_open=1 for 6 cycles, then ud_mode=00 after allReq clears.
- From floor 1, allReq=0100 with up_need; allReq adds 0010 before the first step -> stop at floor 2 (door 6 cycles), continue to floor 3, stop, then idle.
- At floor 3 moving up with allReq=0001 only -> door expiry reverses ud_mode to 10. position reaches 0001 after 8 cycles.
- door_hold pulsed high for 10 cycles mid-door -> door_open stays high for 10 + 6 cycles after release starts the count.
- rst_n asserted while moving between floors 2 and 3 -> outputs return to reset values asynchronously, before the next clk edge.
